// File: rtl/n64_cart_pkg.sv
/*------------------------------------------------------------------------------
 * Module   : n64_cart_pkg
 * Purpose  : Shared types, magic bytes and helpers for the N64 cart downloader.
 * Revision : 1.0  initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

package n64_cart_pkg;

   typedef enum logic [1:0] {
      FMT_Z64 = 2'd0,
      FMT_V64 = 2'd1,
      FMT_N64 = 2'd2
   } cart_fmt_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_FLUSH = 2'd2
   } load_state_e;

   typedef enum logic [0:0] {
      W_IDLE = 1'b0,
      W_BUSY = 1'b1
   } wr_state_e;

   localparam logic [7:0]  c_magic_z64  = 8'h80;
   localparam logic [7:0]  c_magic_v64  = 8'h37;
   localparam logic [7:0]  c_magic_n64  = 8'h40;
   localparam logic [26:0] c_hdr_id_off = 27'h3C;
   localparam logic [63:0] c_pal_list   = "DFIPSUXY";

   function automatic logic is_pal_region(input logic [7:0] code);
      logic r_hit;
      r_hit = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (code == c_pal_list[i*8 +: 8]) r_hit = 1'b1;
      end
      return r_hit;
   endfunction

   // h0 is the halfword at the lower file address; bytes arrive as {later, earlier}
   function automatic logic [31:0] normalise(input cart_fmt_e fmt,
                                             input logic [15:0] h0,
                                             input logic [15:0] h1);
      logic [31:0] w_word;
      case (fmt)
         FMT_V64: w_word = {h0[15:8], h0[7:0], h1[15:8], h1[7:0]};
         FMT_N64: w_word = {h1[15:8], h1[7:0], h0[15:8], h0[7:0]};
         default: w_word = {h0[7:0], h0[15:8], h1[7:0], h1[15:8]};
      endcase
      return w_word;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cart_word_fifo.sv
/*------------------------------------------------------------------------------
 * Module   : cart_word_fifo
 * Purpose  : Show-ahead synchronous FIFO with occupancy count; full pushes drop.
 * Revision : 1.0  initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module cart_word_fifo #(
   parameter int WIDTH = 59,
   parameter int DEPTH = 4
) (
   input  logic                     clk1x,
   input  logic                     reset_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_din,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_dout,
   output logic                     o_empty,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int c_aw = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wptr;
   logic [c_aw-1:0]  r_rptr;
   logic [c_aw:0]    r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == (c_aw+1)'(DEPTH));
   assign o_count   = r_count;
   assign o_dout    = r_mem[r_rptr];
   assign w_push_ok = i_push & ~o_full;
   assign w_pop_ok  = i_pop & ~o_empty;

   always_ff @(posedge clk1x) begin
      if (w_push_ok) r_mem[r_wptr] <= i_din;
   end

   always_ff @(posedge clk1x or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + 1'b1;
         if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/cart_download_packer.sv
/*------------------------------------------------------------------------------
 * Module   : cart_download_packer
 * Purpose  : Packs ioctl halfwords into big-endian ROM words and writes SDRAM.
 * Revision : 1.0  initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module cart_download_packer
   import n64_cart_pkg::*;
#(
   parameter logic [26:0] CART_BASE  = 27'd8388608,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [5:0]  DL_INDEX   = 6'd1
) (
   input  logic        clk1x,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic [26:0] ioctl_addr,
   input  logic [15:0] ioctl_dout,
   input  logic        ioctl_wr,
   output logic        ioctl_wait,
   output logic [26:0] sdram_addr,
   output logic [31:0] sdram_din,
   output logic        sdram_req,
   input  logic        sdram_ready,
   output logic        cart_busy,
   output logic        cart_done,
   output logic [26:0] cart_size,
   output logic [15:0] cart_id,
   output logic        region_pal,
   output logic        fmt_error,
   output logic        overflow
);

   localparam int c_cw = $clog2(FIFO_DEPTH) + 1;

   load_state_e      r_state;
   wr_state_e        r_wstate;
   cart_fmt_e        r_fmt;
   logic             r_sel, r_sel_d, r_start_pend;
   logic             r_pend_valid;
   logic [15:0]      r_pend_data;
   logic [26:2]      r_pend_addr;
   logic             r_wait, r_done, r_req;
   logic [26:0]      r_addr, r_size;
   logic [31:0]      r_din;
   logic [15:0]      r_cart_id;
   logic             r_region_pal, r_fmt_error, r_overflow;

   logic             w_sel, w_rise, w_wr_acc, w_tail;
   logic             w_push, w_pop, w_push_ok;
   logic [15:0]      w_h0, w_h1;
   logic [26:0]      w_off, w_push_addr;
   logic [31:0]      w_word;
   logic [58:0]      w_fifo_dout;
   logic             w_empty, w_full;
   logic [c_cw-1:0]  w_count, w_cnt_next;

   // Upper index bits are don't-care; compare against themselves to keep them in use
   assign w_sel    = ioctl_download && (ioctl_index == {ioctl_index[7:6], DL_INDEX});
   assign w_rise   = r_sel & ~r_sel_d;
   assign w_wr_acc = ioctl_wr & w_sel & r_sel & (r_state == S_LOAD);
   assign w_tail   = (r_state == S_LOAD) & ~r_sel & r_pend_valid;

   always_comb begin
      w_push = 1'b0;
      w_h0   = '0;
      w_h1   = '0;
      w_off  = '0;
      if (w_wr_acc && ioctl_addr[1]) begin
         w_push = 1'b1;
         w_h0   = r_pend_valid ? r_pend_data : 16'h0000;
         w_h1   = ioctl_dout;
         w_off  = {ioctl_addr[26:2], 2'b00};
      end else if (w_tail) begin
         w_push = 1'b1;
         w_h0   = r_pend_data;
         w_off  = {r_pend_addr, 2'b00};
      end
   end

   assign w_word      = normalise(r_fmt, w_h0, w_h1);
   assign w_push_addr = CART_BASE + w_off;
   assign w_push_ok   = w_push & ~w_full;
   assign w_pop       = (r_wstate == W_IDLE) & ~w_empty;
   assign w_cnt_next  = w_count + c_cw'(w_push_ok) - c_cw'(w_pop);

   cart_word_fifo #(
      .WIDTH (59),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk1x   (clk1x),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_din   ({w_push_addr, w_word}),
      .i_pop   (w_pop),
      .o_dout  (w_fifo_dout),
      .o_empty (w_empty),
      .o_full  (w_full),
      .o_count (w_count)
   );

   always_ff @(posedge clk1x or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_fmt        <= FMT_Z64;
         r_sel        <= 1'b0;
         r_sel_d      <= 1'b0;
         r_start_pend <= 1'b0;
         r_pend_valid <= 1'b0;
         r_pend_data  <= '0;
         r_pend_addr  <= '0;
         r_wait       <= 1'b0;
         r_done       <= 1'b0;
         r_size       <= '0;
         r_cart_id    <= '0;
         r_region_pal <= 1'b0;
         r_fmt_error  <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_sel   <= w_sel;
         r_sel_d <= r_sel;
         r_done  <= 1'b0;
         r_wait  <= (r_state == S_LOAD) && r_sel && (w_cnt_next >= c_cw'(FIFO_DEPTH - 1));
         if (w_rise) r_start_pend <= 1'b1;

         if (w_wr_acc) begin
            if (!ioctl_addr[1]) begin
               r_pend_valid <= 1'b1;
               r_pend_data  <= ioctl_dout;
               r_pend_addr  <= ioctl_addr[26:2];
            end else begin
               r_pend_valid <= 1'b0;
            end
            if (ioctl_addr == 27'd0) begin
               case (ioctl_dout[7:0])
                  c_magic_z64: r_fmt <= FMT_Z64;
                  c_magic_v64: r_fmt <= FMT_V64;
                  c_magic_n64: r_fmt <= FMT_N64;
                  default: begin
                     r_fmt       <= FMT_Z64;
                     r_fmt_error <= 1'b1;
                  end
               endcase
            end
         end
         if (w_tail) r_pend_valid <= 1'b0;

         if (w_push) begin
            if (w_full) r_overflow <= 1'b1;
            else if ((w_off + 27'd4) > r_size) r_size <= w_off + 27'd4;
            if (w_off == c_hdr_id_off) begin
               r_cart_id    <= w_word[31:16];
               r_region_pal <= is_pal_region(w_word[15:8]);
            end
         end

         case (r_state)
            S_IDLE: begin
               if (w_rise || r_start_pend) begin
                  r_state      <= S_LOAD;
                  r_start_pend <= 1'b0;
                  r_fmt        <= FMT_Z64;
                  r_pend_valid <= 1'b0;
                  r_size       <= '0;
                  r_cart_id    <= '0;
                  r_region_pal <= 1'b0;
                  r_fmt_error  <= 1'b0;
                  r_overflow   <= 1'b0;
               end
            end
            S_LOAD: begin
               if (!r_sel) r_state <= S_FLUSH;
            end
            S_FLUSH: begin
               if (w_empty && (r_wstate == W_IDLE)) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // A ready seen while idle belongs to no request and is dropped
   always_ff @(posedge clk1x or negedge reset_n) begin
      if (!reset_n) begin
         r_wstate <= W_IDLE;
         r_req    <= 1'b0;
         r_addr   <= '0;
         r_din    <= '0;
      end else begin
         r_req <= 1'b0;
         case (r_wstate)
            W_IDLE: begin
               if (!w_empty) begin
                  r_addr   <= w_fifo_dout[58:32];
                  r_din    <= w_fifo_dout[31:0];
                  r_req    <= 1'b1;
                  r_wstate <= W_BUSY;
               end
            end
            W_BUSY: begin
               if (sdram_ready) r_wstate <= W_IDLE;
            end
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

   assign ioctl_wait = r_wait;
   assign sdram_addr = r_addr;
   assign sdram_din  = r_din;
   assign sdram_req  = r_req;
   assign cart_busy  = (r_state != S_IDLE);
   assign cart_done  = r_done;
   assign cart_size  = r_size;
   assign cart_id    = r_cart_id;
   assign region_pal = r_region_pal;
   assign fmt_error  = r_fmt_error;
   assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_cart_download_packer.sv
/*------------------------------------------------------------------------------
 * Module   : tb_cart_download_packer
 * Purpose  : Directed table-driven bench for cart_download_packer.
 * Revision : 1.0  initial release
 *----------------------------------------------------------------------------*/
`default_nettype none
`timescale 1ns/1ps

module tb_cart_download_packer;

   logic        clk1x = 1'b0;
   logic        reset_n;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic [26:0] ioctl_addr;
   logic [15:0] ioctl_dout;
   logic        ioctl_wr;
   logic        ioctl_wait;
   logic [26:0] sdram_addr;
   logic [31:0] sdram_din;
   logic        sdram_req;
   logic        sdram_ready;
   logic        cart_busy, cart_done, region_pal, fmt_error, overflow;
   logic [26:0] cart_size;
   logic [15:0] cart_id;

   always #5 clk1x = ~clk1x;

   cart_download_packer dut (
      .clk1x          (clk1x),
      .reset_n        (reset_n),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wr       (ioctl_wr),
      .ioctl_wait     (ioctl_wait),
      .sdram_addr     (sdram_addr),
      .sdram_din      (sdram_din),
      .sdram_req      (sdram_req),
      .sdram_ready    (sdram_ready),
      .cart_busy      (cart_busy),
      .cart_done      (cart_done),
      .cart_size      (cart_size),
      .cart_id        (cart_id),
      .region_pal     (region_pal),
      .fmt_error      (fmt_error),
      .overflow       (overflow)
   );

   typedef struct {
      int          fmt;      // 0 z64, 1 v64, 2 n64 file layout
      int          nbytes;
      int          lat;
      logic [7:0]  b0;
      logic [7:0]  reg_b;
      int          exp_nwr;
      int          exp_size;
      logic [15:0] exp_id;
      logic        exp_pal;
      logic        exp_err;
      logic        exp_wait;
   } vec_t;

   vec_t        vecs [8];
   logic [7:0]  rom [64];
   logic [58:0] cap_q [$];
   int          lat = 0;
   int          done_cnt = 0;
   int          wait_cnt = 0;
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // SDRAM model: captures each request, answers with ready after lat cycles
   initial begin
      sdram_ready = 1'b0;
      forever begin
         @(negedge clk1x);
         if (sdram_req) begin
            cap_q.push_back({sdram_addr, sdram_din});
            repeat (lat) @(negedge clk1x);
            sdram_ready = 1'b1;
            @(negedge clk1x);
            sdram_ready = 1'b0;
         end
      end
   end

   always @(negedge clk1x) begin
      if (cart_done)  done_cnt++;
      if (ioctl_wait) wait_cnt++;
   end

   function automatic logic [7:0] fbyte(input int fmt, input int i, input int n);
      if (i >= n) return 8'h00;
      case (fmt)
         1:       return rom[i ^ 1];
         2:       return rom[i ^ 3];
         default: return rom[i];
      endcase
   endfunction

   function automatic logic [7:0] rbyte(input int i, input int n);
      return (i < n) ? rom[i] : 8'h00;
   endfunction

   task automatic fill_rom(input logic [7:0] b0, input logic [7:0] reg_b);
      for (int i = 0; i < 64; i++) rom[i] = 8'((i * 13) + 5);
      rom[0] = b0;     rom[1] = 8'h37;  rom[2] = 8'h12;  rom[3] = 8'h40;
      rom[60] = 8'h4E; rom[61] = 8'h53; rom[62] = reg_b; rom[63] = 8'h00;
   endtask

   task automatic send_halfwords(input int fmt, input int first, input int nbytes, input int total);
      for (int a = first; a < nbytes; a += 2) begin
         int g = 0;
         while (ioctl_wait && g < 500) begin
            @(posedge clk1x); #1;
            g++;
         end
         if (g >= 500) chk("wait_timeout", 1, 0);
         ioctl_addr = 27'(a);
         ioctl_dout = {fbyte(fmt, a + 1, total), fbyte(fmt, a, total)};
         ioctl_wr   = 1'b1;
         @(posedge clk1x); #1;
         ioctl_wr   = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int g = 0;
      while (cart_busy && g < 3000) begin
         @(posedge clk1x); #1;
         g++;
      end
      if (g >= 3000) chk("done_timeout", 1, 0);
      repeat (2) @(negedge clk1x);
   endtask

   task automatic run_vec(input int vi, input vec_t v);
      int    c0, d0, w0;
      string tag;
      tag = $sformatf("v%0d", vi);
      fill_rom(v.b0, v.reg_b);
      lat = v.lat;
      c0  = cap_q.size();
      d0  = done_cnt;
      w0  = wait_cnt;
      ioctl_index    = 8'd1;
      ioctl_download = 1'b1;
      repeat (3) @(posedge clk1x); #1;
      send_halfwords(v.fmt, 0, v.nbytes, v.nbytes);
      chk({tag, "_busy"}, 64'(cart_busy), 1);
      ioctl_download = 1'b0;
      wait_idle();
      chk({tag, "_nwr"}, 64'(cap_q.size() - c0), 64'(v.exp_nwr));
      for (int k = 0; k < v.exp_nwr && (c0 + k) < cap_q.size(); k++) begin
         chk($sformatf("%s_w%0d", tag, k), 64'(cap_q[c0 + k]),
             64'({27'h800000 + 27'(4 * k),
                  rbyte(4*k, v.nbytes), rbyte(4*k+1, v.nbytes),
                  rbyte(4*k+2, v.nbytes), rbyte(4*k+3, v.nbytes)}));
      end
      chk({tag, "_size"},  64'(cart_size),  64'(v.exp_size));
      chk({tag, "_id"},    64'(cart_id),    64'(v.exp_id));
      chk({tag, "_pal"},   64'(region_pal), 64'(v.exp_pal));
      chk({tag, "_ferr"},  64'(fmt_error),  64'(v.exp_err));
      chk({tag, "_ovf"},   64'(overflow),   0);
      chk({tag, "_done"},  64'(done_cnt - d0), 1);
      chk({tag, "_wait"},  64'(wait_cnt != w0), 64'(v.exp_wait));
   endtask

   initial begin
      int c0, d0, g;
      //            fmt nb  lat b0     reg    nwr sz  id        pal   err   wait
      vecs[0] = '{0, 64, 0,  8'h80, 8'h50, 16, 64, 16'h4E53, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{1, 64, 0,  8'h80, 8'h50, 16, 64, 16'h4E53, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{2, 64, 0,  8'h80, 8'h50, 16, 64, 16'h4E53, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{0, 64, 0,  8'h80, 8'h45, 16, 64, 16'h4E53, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{0, 64, 20, 8'h80, 8'h50, 16, 64, 16'h4E53, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{0, 6,  0,  8'h80, 8'h50, 2,  8,  16'h0000, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{0, 14, 0,  8'h80, 8'h50, 4,  16, 16'h0000, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{0, 64, 0,  8'h12, 8'h59, 16, 64, 16'h4E53, 1'b1, 1'b1, 1'b0};

      reset_n        = 1'b0;
      ioctl_download = 1'b0;
      ioctl_index    = 8'd0;
      ioctl_addr     = '0;
      ioctl_dout     = '0;
      ioctl_wr       = 1'b0;
      repeat (3) @(negedge clk1x);
      chk("rst_req",   64'(sdram_req),  0);
      chk("rst_busy",  64'(cart_busy),  0);
      chk("rst_wait",  64'(ioctl_wait), 0);
      chk("rst_addr",  64'(sdram_addr), 0);
      chk("rst_din",   64'(sdram_din),  0);
      chk("rst_size",  64'(cart_size),  0);
      chk("rst_flags", 64'({cart_done, cart_id, region_pal, fmt_error, overflow}), 0);
      @(posedge clk1x); #1;
      reset_n = 1'b1;
      repeat (2) @(posedge clk1x); #1;

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      // Reset while a write is outstanding
      fill_rom(8'h80, 8'h50);
      lat = 50;
      c0  = cap_q.size();
      d0  = done_cnt;
      ioctl_index    = 8'd1;
      ioctl_download = 1'b1;
      repeat (3) @(posedge clk1x); #1;
      send_halfwords(0, 0, 8, 64);
      g = 0;
      while (cap_q.size() == c0 && g < 50) begin
         @(posedge clk1x); #1;
         g++;
      end
      chk("rb_req_seen", 64'(cap_q.size() > c0), 1);
      @(posedge clk1x); #1;
      reset_n        = 1'b0;
      ioctl_download = 1'b0;
      #2;
      chk("rb_req",   64'(sdram_req),  0);
      chk("rb_busy",  64'(cart_busy),  0);
      chk("rb_data",  64'({sdram_addr, sdram_din}), 0);
      chk("rb_size",  64'(cart_size),  0);
      @(posedge clk1x); #1;
      reset_n = 1'b1;
      repeat (70) @(posedge clk1x); #1;
      chk("rb_nodone", 64'(done_cnt - d0), 0);
      chk("rb_idle",   64'(cart_busy), 0);
      chk("rb_noreq",  64'(cap_q.size() - c0), 1);
      run_vec(8, vecs[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running required finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/cart_download_packer.md
Name: cart_download_packer

Overview:
- Sits between the HPS ioctl download port and SDRAM channel 2; replaces the inline cart-download packing in the top level.
- Accepts 16-bit ioctl halfwords, auto-detects ROM byte order (.z64/.v64/.n64) and normalises every word to big-endian.
- Buffers words in a small FIFO and writes them to SDRAM with a req/ready handshake, throttling the HPS via ioctl_wait.
- Captures header fields (cart ID, region) for system auto-detect, and reports size and completion.

Parameters:
- CART_BASE, 8388608, SDRAM byte address of ROM byte 0.
- FIFO_DEPTH, 4, word FIFO entries (power of 2, >=4).
- DL_INDEX, 1, ioctl_index[5:0] value that selects this block.

Ports:
- clk1x  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  HPS download active.
- ioctl_index  in  8  download index.
- ioctl_addr  in  27  byte address of the current halfword.
- ioctl_dout  in  16  data; [7:0] is the earlier file byte.
- ioctl_wr  in  1  halfword strobe.
- ioctl_wait  out  1  stall request to HPS.
- sdram_addr  out  27  write byte address.
- sdram_din  out  32  big-endian write word.
- sdram_req  out  1  single-cycle write request.
- sdram_ready  in  1  single-cycle write completion.
- cart_busy  out  1  download or flush in progress (holds core in reset).
- cart_done  out  1  one-cycle pulse when the last write completes.
- cart_size  out  27  bytes written, rounded up to a multiple of 4.
- cart_id  out  16  header bytes 0x3C..0x3D.
- region_pal  out  1  header byte 0x3E is in {D,F,I,P,S,U,X,Y}.
- fmt_error  out  1  sticky: first byte not 0x80/0x37/0x40.
- overflow  out  1  sticky: write arrived while FIFO full.

Behaviour:
- Reset: all outputs 0; FSM IDLE; FIFO empty.
- sel = ioctl_download & (ioctl_index[5:0]==DL_INDEX), registered once.
- Main FSM:
  - IDLE -> LOAD on the rising edge of sel. On entry, clear counters, pending-half register, cart_id, region_pal, fmt_error and overflow.
  - LOAD -> FLUSH on the falling edge of sel. An abort mid-file is treated the same as a normal end.
  - FLUSH -> IDLE once the FIFO is empty and no request is outstanding; cart_done pulses in that same cycle.
  - cart_busy = (state != IDLE).
- Format latch (ioctl_wr at addr 0): ioctl_dout[7:0]==0x80 -> Z64, 0x37 -> V64, 0x40 -> N64. Any other value -> Z64 and set fmt_error.
- Packing:
  - addr[1]=0 halfword is held in the pending register.
  - addr[1]=1 completes the word. With h0 = first halfword and h1 = second, normalised word W:
    - Z64: {h0[7:0],h0[15:8],h1[7:0],h1[15:8]}
    - V64: {h0[15:8],h0[7:0],h1[15:8],h1[7:0]}
    - N64: {h1[15:8],h1[7:0],h0[15:8],h0[7:0]}
  - W is pushed with address CART_BASE + {addr[26:2],2'b00}, 27-bit wrap.
- Tail: on entering FLUSH with a pending half, push it with zeros in the missing half. cart_size = highest pushed byte address + 4 - CART_BASE.
- Header: when the pushed word address is 0x3C, cart_id = W[31:16] and region_pal is decoded from W[15:8].
- FIFO:
  - One push and one pop can occur in the same cycle.
  - A push when full is dropped and sets overflow.
  - ioctl_wait is registered: it is 1 while occupancy after this cycle >= FIFO_DEPTH-1, which guarantees one free slot for a late strobe. It is forced 0 outside LOAD.
- Writer:
  - W_IDLE: if FIFO non-empty, pop, drive addr/din, pulse sdram_req for 1 cycle -> W_BUSY.
  - W_BUSY: addr/din held stable; on sdram_ready -> W_IDLE. A new request can issue the cycle after ready.
  - A sdram_ready arriving in W_IDLE is ignored.
- Latency: ioctl_wr of the second half -> sdram_req >= 2 cycles (push, then pop) when the FIFO is empty and the writer is idle.
- Reset mid-transfer: all state is cleared immediately, with no done pulse. An outstanding SDRAM write is abandoned, and a late sdram_ready after reset is ignored.
- A new rising edge of sel while in FLUSH is held off until IDLE; the edge detector latches it.

Decomposition:
- Package n64_cart_pkg: format enum (FMT_Z64, FMT_V64, FMT_N64), magic byte constants, PAL region byte list, header offset 0x3C.
- Sub-module cart_word_fifo: parameterised synchronous FIFO with count output. The packer, format detect and writer FSM stay in the top module.

Test Plan:
- Z64 file 80 37 12 40 .. (64 bytes), zero-latency ready -> first sdram_din 0x80371240 at addr 0x800000; 16 writes; cart_size=64; one cart_done.
- Same ROM as V64 (37 80 40 12..) and as N64 (40 12 37 80..) -> sdram_din stream identical to Z64 case; fmt_error=0.
- Header bytes 0x3C..0x3F = 4E 53 50 00 ('N','S','P') -> cart_id=0x4E53, region_pal=1; with 0x45 ('E') -> region_pal=0.
- sdram_ready delayed 20 cycles, back-to-back ioctl_wr -> ioctl_wait asserts at occupancy 3, overflow stays 0, no word lost or reordered.
- 6-byte file -> second write data {b4,b5,00,00}, cart_size=8; download dropped mid-word -> FLUSH pads and cart_done pulses.
- reset_n low while in W_BUSY -> all outputs 0 next edge, late sdram_ready ignored, next download starts clean.
